key_sprite_scheduler: RTL and testbench
=======================================

// Module: key_sprite_scheduler
// PURPOSE
//  Time-multiplexes one shared piano-key sprite datapath across NUM_KEYS white keys along each scanline.
//  Tracks hcount/vcount and selects the active key index.
//  Drives that key's x/y origin, shape type and highlight colour, registered, to the downstream key sprite.
//  Sits between the key-press detector and the key sprite/pixel mixer in the XGA video path.
// PARAMETERS
//  NUM_KEYS         8    white keys drawn, 2..16
//  WHITE_KEY_WIDTH  90   key pitch in pixels
//  KEY_X0           0    left edge of key 0
//  KEY_Y0           100  top edge of all keys
// PORTS
//  clock        in   1    pixel clock
//  reset_n      in   1    asynchronous, active-low reset
//  hcount       in   11   current pixel column
//  vcount       in   10   current pixel row
//  key_pressed  in   NUM_KEYS  raw press flags from detector, any time
//  idle_color   in   24   RGB for unpressed key
//  press_color  in   24   RGB for pressed key
//  key_x        out  11   origin x of selected key
//  key_y        out  10   origin y (always KEY_Y0 when valid)
//  key_type     out  2    piano_pkg::key_type_t: NONE/LEFT/MIDDLE/RIGHT
//  key_color    out  24   colour for selected key
//  key_index    out  4    selected key index
//  key_valid    out  1    hcount_d inside key band
//  hcount_d     out  11   hcount delayed 1 cycle, aligned with outputs
//  vcount_d     out  10   vcount delayed 1 cycle
// BEHAVIOUR
//  Reset: all outputs 0; key_type=NONE; idx=0; pressed_q=0; fade levels 0.
//  Latency: 1 clock; outputs registered together with hcount_d/vcount_d.
//  Line scan: hcount==0 -> idx=0, boundary=KEY_X0+WHITE_KEY_WIDTH.
//    hcount==boundary with idx<NUM_KEYS-1 -> idx++, boundary+=WHITE_KEY_WIDTH.
//    Boundary adder is 11-bit; KEY_X0+NUM_KEYS*WIDTH must be <=1024 (elaboration check).
//  Band: hcount in [KEY_X0, KEY_X0+NUM_KEYS*WIDTH) -> key_valid=1; else key_valid=0, key_type=NONE, color 0.
//    key_x=KEY_X0+idx*WIDTH.
//  key_type: idx 0 -> LEFT; idx NUM_KEYS-1 -> RIGHT; others -> MIDDLE.
//  Frame latch: key_pressed sampled into pressed_q only when hcount==0 && vcount==0; no mid-frame tearing.
//  Press pulses shorter than a frame between latches are not captured (intended).
//  Reset mid-line: outputs go to NONE immediately.
//    Scan resumes correctly at the next hcount==0; until then key_valid=0.
//  Colour, no fade: pressed_q[idx] ? press_color : idle_color.
// CONFIGURATION
//  KEY_SPRITE_FADE_EN defined:
//    Per-key 4-bit level. At frame latch: pressed -> level=15; released and level>0 -> level-1.
//    Per 8-bit channel: color = (press*level + idle*(15-level)) >> 4.
//    Result is registered, so latency stays 1. Re-press mid-fade reloads 15.
//  KEY_SPRITE_FADE_EN undefined: no level registers; colour snaps per frame.
// STRUCTURE
//  piano_pkg:
//    key_type_t enum (NONE=0, LEFT=1, MIDDLE=2, RIGHT=3).
//    H_ACTIVE=1024, V_ACTIVE=768.
//    FADE_MAX=15.
//  Sub-module key_fade_ctr: one per key via generate, only under KEY_SPRITE_FADE_EN.
//    Inputs: frame_tick, pressed. Output: level[3:0].
//  Scan counter, band compare and output register stay in this module.
// TESTING
//  Reset: reset_n low, hcount sweeping -> all outputs 0, key_type=NONE; on release, valid keys appear from next hcount==0.
//  Scan: defaults, one line 0..1023 -> key_index steps 0..7 at hcount_d 90,180,..,630.
//    Types LEFT,MIDDLE x6,RIGHT; key_valid=0 from hcount_d 720.
//  Frame latch: key_pressed=8'h04 asserted mid-frame -> key 2 colour unchanged until after (0,0); then press_color on key 2 only.
//  Short pulse: key_pressed=8'h01 for 100 clocks, entirely between latches -> never visible.
//  Fade (EN): press key 3 one frame, release -> level 15,14,..,0 over 15 frames.
//    idle=0, press=FFFFFF: colour 0xEFEFEF at level 15, 0 at level 0.
//  Offset: KEY_X0=100, NUM_KEYS=4 -> key_valid=1 for hcount_d in [100,460); key_x=100,190,280,370.

Source files
------------

// File: rtl/piano_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : piano_pkg
//  Purpose  : Shared types and constants for the piano-key video path.
//             key_type_t selects the sprite outline drawn for a key; the
//             blend helper mixes two 8-bit channels by a 4-bit level.
//  Revision : 1.0  initial release
// ============================================================================
package piano_pkg;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        LEFT   = 2'd1,
        MIDDLE = 2'd2,
        RIGHT  = 2'd3
    } key_type_t;

    localparam int         H_ACTIVE = 1024;
    localparam int         V_ACTIVE = 768;
    localparam logic [3:0] FADE_MAX = 4'd15;

    // (hi*level + lo*(15-level)) >> 4. Worst case 255*15 = 3825 fits 12 bits.
    function automatic logic [7:0] blend_channel(input logic [7:0] hi,
                                                 input logic [7:0] lo,
                                                 input logic [3:0] level);
        logic [11:0] sum;
        sum = 12'(hi) * 12'(level) + 12'(lo) * 12'(FADE_MAX - level);
        return sum[11:4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_fade_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : key_fade_ctr
//  Purpose  : Per-key 4-bit highlight level. Loads FADE_MAX on a frame tick
//             while the key is pressed, otherwise decays by one per frame
//             tick down to zero.
//  Config   : compiled only when KEY_SPRITE_FADE_EN is defined.
//  Ports    : clock, reset_n (async active-low)
//             frame_tick  in  1  one-cycle pulse at pixel (0,0)
//             pressed     in  1  raw press flag for this key
//             level       out 4  current highlight level
//  Revision : 1.0  initial release
// ============================================================================
`ifdef KEY_SPRITE_FADE_EN
module key_fade_ctr
    import piano_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       pressed,
    output logic [3:0] level
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level <= 4'd0;
        end else if (frame_tick) begin
            if (pressed) begin
                level <= FADE_MAX;
            end else if (level != 4'd0) begin
                level <= level - 4'd1;
            end
        end
    end

endmodule
`endif
`default_nettype wire

// File: rtl/key_sprite_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : key_sprite_scheduler
//  Purpose  : Time-multiplexes one key sprite datapath across NUM_KEYS white
//             keys along each scanline. Tracks hcount, selects the active
//             key and presents its origin, outline type and colour one clock
//             later, aligned with hcount_d/vcount_d.
//  Config   : KEY_SPRITE_FADE_EN - per-key fade levels blend press/idle
//             colours; otherwise colour snaps once per frame.
//  Ports    : clock, reset_n (async active-low)
//             hcount[10:0], vcount[9:0]   current pixel position
//             key_pressed[NUM_KEYS-1:0]   raw press flags, sampled at (0,0)
//             idle_color, press_color     24-bit RGB
//             key_x, key_y, key_type, key_color, key_index, key_valid
//             hcount_d, vcount_d          position delayed to match outputs
//  Revision : 1.0  initial release
// ============================================================================
module key_sprite_scheduler
    import piano_pkg::*;
#(
    parameter int NUM_KEYS        = 8,
    parameter int WHITE_KEY_WIDTH = 90,
    parameter int KEY_X0          = 0,
    parameter int KEY_Y0          = 100
)
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic [10:0]         hcount,
    input  logic [9:0]          vcount,
    input  logic [NUM_KEYS-1:0] key_pressed,
    input  logic [23:0]         idle_color,
    input  logic [23:0]         press_color,
    output logic [10:0]         key_x,
    output logic [9:0]          key_y,
    output key_type_t           key_type,
    output logic [23:0]         key_color,
    output logic [3:0]          key_index,
    output logic                key_valid,
    output logic [10:0]         hcount_d,
    output logic [9:0]          vcount_d
);

    localparam logic [10:0] c_band_lo        = 11'(KEY_X0);
    localparam logic [10:0] c_band_w         = 11'(NUM_KEYS * WHITE_KEY_WIDTH);
    localparam logic [10:0] c_width          = 11'(WHITE_KEY_WIDTH);
    localparam logic [10:0] c_first_boundary = 11'(KEY_X0 + WHITE_KEY_WIDTH);
    localparam logic [3:0]  c_last_idx       = 4'(NUM_KEYS - 1);
    localparam logic [9:0]  c_key_y0         = 10'(KEY_Y0);

    // The boundary adder is 11 bits wide; the key band must end within the
    // active line.
    generate
        if ((KEY_X0 + NUM_KEYS * WHITE_KEY_WIDTH > H_ACTIVE) ||
            (NUM_KEYS < 2) || (NUM_KEYS > 16)) begin : g_bad_params
            $error("key_sprite_scheduler: key band exceeds active line or NUM_KEYS out of 2..16");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------
    logic [3:0]  r_idx;
    logic [10:0] r_boundary;
    logic        r_scan_ok;     // a line start has been seen since reset

    logic [3:0]  w_idx;
    logic [10:0] w_boundary;
    logic        w_line_start;
    logic        w_scan_ok;
    logic        w_frame_tick;
    logic [10:0] w_rel;
    logic        w_in_band;
    logic [10:0] w_key_x;
    key_type_t   w_type;
    logic [23:0] w_color;

    assign w_line_start = (hcount == 11'd0);
    assign w_frame_tick = w_line_start && (vcount == 10'd0);
    assign w_scan_ok    = r_scan_ok || w_line_start;

    // Index/boundary for the pixel presented this cycle. The step happens on
    // the pixel that equals the boundary so key n covers [x0+n*W, x0+(n+1)*W).
    always_comb begin
        w_idx      = r_idx;
        w_boundary = r_boundary;
        if (w_line_start) begin
            w_idx      = 4'd0;
            w_boundary = c_first_boundary;
        end else if ((hcount == r_boundary) && (r_idx < c_last_idx)) begin
            w_idx      = r_idx + 4'd1;
            w_boundary = r_boundary + c_width;
        end
    end

    // Single unsigned compare for the band: when hcount < KEY_X0 the
    // subtraction wraps to at least 2048-KEY_X0, which always exceeds the
    // band width (at most 1024-KEY_X0).
    assign w_rel     = hcount - c_band_lo;
    assign w_in_band = w_scan_ok && (w_rel < c_band_w);

    // Boundary always sits one key ahead of the selected key's origin.
    assign w_key_x = w_boundary - c_width;

    always_comb begin
        w_type = MIDDLE;
        if (w_idx == 4'd0) begin
            w_type = LEFT;
        end else if (w_idx == c_last_idx) begin
            w_type = RIGHT;
        end
    end

    // ------------------------------------------------------------------
    // Colour selection
    // ------------------------------------------------------------------
`ifdef KEY_SPRITE_FADE_EN
    logic [3:0] w_level [NUM_KEYS];
    logic [3:0] w_sel_level;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_fade
            key_fade_ctr u_fade (
                .clock      (clock),
                .reset_n    (reset_n),
                .frame_tick (w_frame_tick),
                .pressed    (key_pressed[gi]),
                .level      (w_level[gi])
            );
        end
    endgenerate

    always_comb begin
        w_sel_level = 4'd0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (w_idx == 4'(k)) begin
                w_sel_level = w_level[k];
            end
        end
    end

    assign w_color = {blend_channel(press_color[23:16], idle_color[23:16], w_sel_level),
                      blend_channel(press_color[15:8],  idle_color[15:8],  w_sel_level),
                      blend_channel(press_color[7:0],   idle_color[7:0],   w_sel_level)};
`else
    logic [NUM_KEYS-1:0] r_pressed_q;
    logic                w_sel_pressed;

    // Press flags only change at the frame origin so a frame never tears.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pressed_q <= '0;
        end else if (w_frame_tick) begin
            r_pressed_q <= key_pressed;
        end
    end

    always_comb begin
        w_sel_pressed = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (w_idx == 4'(k)) begin
                w_sel_pressed = r_pressed_q[k];
            end
        end
    end

    assign w_color = w_sel_pressed ? press_color : idle_color;
`endif

    // ------------------------------------------------------------------
    // Scan registers and output stage
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idx      <= 4'd0;
            r_boundary <= c_first_boundary;
            r_scan_ok  <= 1'b0;
            hcount_d   <= 11'd0;
            vcount_d   <= 10'd0;
            key_valid  <= 1'b0;
            key_index  <= 4'd0;
            key_x      <= 11'd0;
            key_y      <= 10'd0;
            key_type   <= NONE;
            key_color  <= 24'd0;
        end else begin
            r_idx      <= w_idx;
            r_boundary <= w_boundary;
            r_scan_ok  <= w_scan_ok;
            hcount_d   <= hcount;
            vcount_d   <= vcount;
            key_valid  <= w_in_band;
            key_index  <= w_in_band ? w_idx    : 4'd0;
            key_x      <= w_in_band ? w_key_x  : 11'd0;
            key_y      <= w_in_band ? c_key_y0 : 10'd0;
            key_type   <= w_in_band ? w_type   : NONE;
            key_color  <= w_in_band ? w_color  : 24'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_sprite_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_sprite_scheduler
//  Purpose  : Self-checking bench. Two instances (default geometry and an
//             offset 4-key band) share the video timing; a behavioural model
//             derives the expected key from the pixel position directly.
//  Revision : 1.0  initial release
// ============================================================================
module tb_key_sprite_scheduler;
    import piano_pkg::*;

    localparam int KW  = 90;
    localparam int KY0 = 100;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [7:0]  kp_a;
    logic [3:0]  kp_b;
    logic [23:0] idle_color, press_color;

    logic [10:0] kx_a, kx_b, hd_a, hd_b;
    logic [9:0]  ky_a, ky_b, vd_a, vd_b;
    key_type_t   kt_a, kt_b;
    logic [23:0] kc_a, kc_b;
    logic [3:0]  ki_a, ki_b;
    logic        kv_a, kv_b;

    always #5 clock = ~clock;

    key_sprite_scheduler #(.NUM_KEYS(8), .WHITE_KEY_WIDTH(90), .KEY_X0(0), .KEY_Y0(100)) u_dut_a (
        .clock(clock), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
        .key_pressed(kp_a), .idle_color(idle_color), .press_color(press_color),
        .key_x(kx_a), .key_y(ky_a), .key_type(kt_a), .key_color(kc_a),
        .key_index(ki_a), .key_valid(kv_a), .hcount_d(hd_a), .vcount_d(vd_a));

    key_sprite_scheduler #(.NUM_KEYS(4), .WHITE_KEY_WIDTH(90), .KEY_X0(100), .KEY_Y0(100)) u_dut_b (
        .clock(clock), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
        .key_pressed(kp_b), .idle_color(idle_color), .press_color(press_color),
        .key_x(kx_b), .key_y(ky_b), .key_type(kt_b), .key_color(kc_b),
        .key_index(ki_b), .key_valid(kv_b), .hcount_d(hd_b), .vcount_d(vd_b));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic        v;
        logic [3:0]  idx;
        logic [10:0] x;
        logic [9:0]  y;
        logic [1:0]  t;
        logic [23:0] c;
    } exp_t;

    exp_t        e [2];
    logic [10:0] e_hd;
    logic [9:0]  e_vd;
    int          m_x0 [2] = '{0, 100};
    int          m_n  [2] = '{8, 4};
    bit          m_ok [2];
    bit          m_press [2][16];
    int          m_lvl   [2][16];

    function automatic logic [23:0] mix(input logic [23:0] p, input logic [23:0] i, input int lvl);
        logic [23:0] r;
        for (int ch = 0; ch < 3; ch++) begin
            int pc, ic;
            pc = int'((p >> (8 * ch)) & 24'hFF);
            ic = int'((i >> (8 * ch)) & 24'hFF);
            r[8*ch +: 8] = 8'((pc * lvl + ic * (15 - lvl)) / 16);
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            e[d].v = 1'b0; e[d].idx = '0; e[d].x = '0; e[d].y = '0; e[d].t = '0; e[d].c = '0;
            m_ok[d] = 1'b0;
            for (int k = 0; k < 16; k++) begin
                m_press[d][k] = 1'b0;
                m_lvl[d][k]   = 0;
            end
        end
        e_hd = '0;
        e_vd = '0;
    endtask

    task automatic predict(input int d, input logic [10:0] h, input logic [9:0] v, input logic [15:0] kp);
        int          rel, idx;
        bit          ok, valid;
        logic [23:0] col;
        ok      = m_ok[d] || (h == 11'd0);
        m_ok[d] = ok;
        rel     = int'(h) - m_x0[d];
        valid   = ok && (rel >= 0) && (rel < m_n[d] * KW);
        idx     = valid ? rel / KW : 0;
`ifdef KEY_SPRITE_FADE_EN
        col = mix(press_color, idle_color, m_lvl[d][idx]);
`else
        col = m_press[d][idx] ? press_color : idle_color;
`endif
        e[d].v   = valid;
        e[d].idx = 4'(idx);
        e[d].x   = 11'(m_x0[d] + idx * KW);
        e[d].y   = 10'(KY0);
        e[d].t   = !valid ? 2'd0 : (idx == 0) ? 2'd1 : (idx == m_n[d] - 1) ? 2'd3 : 2'd2;
        e[d].c   = valid ? col : 24'd0;
        if (h == 11'd0 && v == 10'd0) begin
            for (int k = 0; k < m_n[d]; k++) begin
                m_press[d][k] = kp[k];
                m_lvl[d][k]   = kp[k] ? 15 : (m_lvl[d][k] > 0 ? m_lvl[d][k] - 1 : 0);
            end
        end
    endtask

    task automatic compare_all();
        check("a.hcount_d", 32'(hd_a), 32'(e_hd));
        check("a.vcount_d", 32'(vd_a), 32'(e_vd));
        check("a.key_valid", 32'(kv_a), 32'(e[0].v));
        check("a.key_type", 32'(kt_a), 32'(e[0].t));
        check("a.key_color", 32'(kc_a), 32'(e[0].c));
        if (e[0].v) begin
            check("a.key_index", 32'(ki_a), 32'(e[0].idx));
            check("a.key_x", 32'(kx_a), 32'(e[0].x));
            check("a.key_y", 32'(ky_a), 32'(e[0].y));
        end
        check("b.hcount_d", 32'(hd_b), 32'(e_hd));
        check("b.vcount_d", 32'(vd_b), 32'(e_vd));
        check("b.key_valid", 32'(kv_b), 32'(e[1].v));
        check("b.key_type", 32'(kt_b), 32'(e[1].t));
        check("b.key_color", 32'(kc_b), 32'(e[1].c));
        if (e[1].v) begin
            check("b.key_index", 32'(ki_b), 32'(e[1].idx));
            check("b.key_x", 32'(kx_b), 32'(e[1].x));
            check("b.key_y", 32'(ky_b), 32'(e[1].y));
        end
    endtask

    // Drive one pixel, advance one clock, compare #1 after the edge.
    task automatic step(input logic [10:0] h, input logic [9:0] v, input logic [15:0] kp);
        hcount = h;
        vcount = v;
        kp_a   = kp[7:0];
        kp_b   = kp[3:0];
        if (!reset_n) begin
            model_reset();
        end else begin
            predict(0, h, v, kp);
            predict(1, h, v, kp);
            e_hd = h;
            e_vd = v;
        end
        @(posedge clock);
        #1;
        compare_all();
    endtask

    // One scanline 0..len-1. kp_pulse replaces kp_line for [p_at, p_at+p_len).
    // rst_at >= 0 pulses reset_n low for three pixels starting there.
    task automatic run_line(input logic [9:0] v, input int len,
                            input logic [15:0] kp_line, input logic [15:0] kp_pulse,
                            input int p_at, input int p_len, input int rst_at);
        logic [15:0] kp;
        for (int h = 0; h < len; h++) begin
            if (h == rst_at) begin
                reset_n = 1'b0;
                #1;
                model_reset();
                compare_all();
            end
            if (rst_at >= 0 && h == rst_at + 3) reset_n = 1'b1;
            kp = (h >= p_at && h < p_at + p_len) ? kp_pulse : kp_line;
            step(11'(h), v, kp);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        hcount      = '0;
        vcount      = 10'd3;
        kp_a        = '0;
        kp_b        = '0;
        idle_color  = 24'h123456;
        press_color = 24'hABCDEF;
        model_reset();

        // Reset held while hcount sweeps mid-line, then released mid-line.
        for (int h = 500; h < 520; h++) step(11'(h), 10'd3, 16'hFFFF);
        reset_n = 1'b1;
        for (int h = 520; h < 1024; h++) step(11'(h), 10'd3, 16'hFFFF);

        // Frame with nothing pressed, then key 2 asserted mid-frame.
        run_line(10'd0, 1024, 16'h0000, 16'h0000, 0, 0, -1);
        run_line(10'd5, 1024, 16'h0000, 16'h0004, 200, 2000, -1);
        run_line(10'd0, 1024, 16'h0004, 16'h0004, 0, 0, -1);
        // Short pulse on key 0 between frame latches.
        run_line(10'd7, 1024, 16'h0000, 16'h0001, 400, 100, -1);
        run_line(10'd0, 1024, 16'h0000, 16'h0000, 0, 0, -1);

        // Randomised lines.
        for (int n = 0; n < 28; n++) begin
            logic [9:0] v;
            int         p_at;
            v           = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 767));
            idle_color  = 24'($urandom);
            press_color = 24'($urandom);
            p_at        = int'($urandom_range(0, 1000));
            run_line(v, 1024, 16'($urandom), 16'($urandom), p_at, int'($urandom_range(1, 300)), -1);
        end

        // Reset asserted mid-line; valid must stay low until the next line.
        run_line(10'd9, 1024, 16'h00FF, 16'h0000, 0, 0, 300);
        run_line(10'd0, 1024, 16'h00A5, 16'h0000, 0, 0, -1);

        // Key 3 pressed for one frame, then released for sixteen frames.
        idle_color  = 24'h000000;
        press_color = 24'hFFFFFF;
        run_line(10'd0, 400, 16'h0008, 16'h0000, 0, 0, -1);
        for (int f = 0; f < 16; f++) run_line(10'd0, 400, 16'h0000, 16'h0000, 0, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
